// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - AXI4-Stream synthetic video frame source with tready back-pressure
module axis_frame_gen #(
    parameter int WIDTH  = 800,
    parameter int HEIGHT = 600,
    parameter int BIT_D  = 8,
    parameter int BIT_F  = 16
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic [1:0]       pattern_i,
    output logic [BIT_D-1:0] tdata_o,
    output logic             tvalid_o,
    input  logic             tready_i,
    output logic             tlast_o,
    output logic             tuser_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [BIT_F-1:0] frame_cnt_o
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    // A 1x1 frame carries both markers on its only beat
    localparam logic ONE_PIXEL = (WIDTH == 1) && (HEIGHT == 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [1:0]       pat_q;
    logic [BIT_D-1:0] tdata_q;
    logic             tvalid_q, tlast_q, tuser_q, busy_q, done_q;
    logic [BIT_F-1:0] cnt_q;
    logic             last_d;
    logic             hs;

    // Pixel value for a coordinate, evaluated at 32 bits then fitted to BIT_D
    function automatic logic [BIT_D-1:0] pixel(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y,
                                               input logic [1:0]    pat);
        logic [31:0] xe;
        logic [31:0] ye;
        xe = 32'(x);
        ye = 32'(y);
        case (pat)
            2'd0:    pixel = BIT_D'(xe + ye);
            2'd1:    pixel = BIT_D'(xe);
            2'd2:    pixel = BIT_D'(ye);
            default: pixel = (xe[3] ^ ye[3]) ? {BIT_D{1'b1}} : '0;
        endcase
    endfunction

    assign hs = tvalid_q & tready_i;

    // Raster advance: coordinate of the pixel following the one being presented
    always_comb begin
        x_d = x_q + XW'(1);
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
        end
        last_d = (x_d == X_LAST) && (y_d == Y_LAST);
    end

    // Frame FSM; every output is registered and only moves on a handshake or frame start
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            pat_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        pat_q    <= pattern_i;
                        x_q      <= '0;
                        y_q      <= '0;
                        tdata_q  <= pixel('0, '0, pattern_i);
                        tvalid_q <= 1'b1;
                        tuser_q  <= 1'b1;
                        tlast_q  <= ONE_PIXEL;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (tlast_q) begin
                            done_q <= 1'b1;
                            cnt_q  <= cnt_q + BIT_F'(1);
                            x_q    <= '0;
                            y_q    <= '0;
                            if (cont_i) begin
                                // Back-to-back frame: first pixel follows with no bubble
                                pat_q   <= pattern_i;
                                tdata_q <= pixel('0, '0, pattern_i);
                                tuser_q <= 1'b1;
                                tlast_q <= ONE_PIXEL;
                            end else begin
                                state_q  <= IDLE;
                                busy_q   <= 1'b0;
                                tvalid_q <= 1'b0;
                                tdata_q  <= '0;
                                tuser_q  <= 1'b0;
                                tlast_q  <= 1'b0;
                            end
                        end else begin
                            x_q     <= x_d;
                            y_q     <= y_d;
                            tdata_q <= pixel(x_d, y_d, pat_q);
                            tuser_q <= 1'b0;
                            tlast_q <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tdata_o      = tdata_q;
    assign tvalid_o     = tvalid_q;
    assign tlast_o      = tlast_q;
    assign tuser_o      = tuser_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - self-checking bench for axis_frame_gen
module tb_axis_frame_gen;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    // Instance A: 4x3 frames
    logic        start_a, cont_a, tready_a;
    logic [1:0]  pattern_a;
    logic [7:0]  tdata_a;
    logic        tvalid_a, tlast_a, tuser_a, busy_a, done_a;
    logic [15:0] cnt_a;

    // Instance B: 16x16 frames, 2-bit frame counter
    logic        start_b, cont_b, tready_b;
    logic [1:0]  pattern_b;
    logic [7:0]  tdata_b;
    logic        tvalid_b, tlast_b, tuser_b, busy_b, done_b;
    logic [1:0]  cnt_b;

    axis_frame_gen #(.WIDTH(4), .HEIGHT(3), .BIT_D(8), .BIT_F(16)) dut_a (
        .clk_i(clk), .arst_ni(arst_n), .start_i(start_a), .cont_i(cont_a),
        .pattern_i(pattern_a), .tdata_o(tdata_a), .tvalid_o(tvalid_a),
        .tready_i(tready_a), .tlast_o(tlast_a), .tuser_o(tuser_a),
        .busy_o(busy_a), .frame_done_o(done_a), .frame_cnt_o(cnt_a)
    );

    axis_frame_gen #(.WIDTH(16), .HEIGHT(16), .BIT_D(8), .BIT_F(2)) dut_b (
        .clk_i(clk), .arst_ni(arst_n), .start_i(start_b), .cont_i(cont_b),
        .pattern_i(pattern_b), .tdata_o(tdata_b), .tvalid_o(tvalid_b),
        .tready_i(tready_b), .tlast_o(tlast_b), .tuser_o(tuser_b),
        .busy_o(busy_b), .frame_done_o(done_b), .frame_cnt_o(cnt_b)
    );

    int checks = 0;
    int errors = 0;
    int cnt_model_a = 0;

    typedef struct { int data; bit user; bit last; } beat_t;
    beat_t expq[$];

    typedef struct { int p0; int p1; int p2; int p3; int nfr; int pct; int exp_beats; } scen_t;
    scen_t sc[5];

    typedef struct { int x; int y; int exp; } pv_t;
    pv_t pv[6];

    int capt[256];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pixel rule straight from the pattern definitions
    function automatic int pix_model(input int x, input int y, input int pat);
        case (pat)
            0:       return (x + y) % 256;
            1:       return x % 256;
            2:       return y % 256;
            default: return (((x / 8) + (y / 8)) % 2 == 1) ? 255 : 0;
        endcase
    endfunction

    // Drive nfr frames through instance A and score every beat against the model
    task automatic run_a(input int p0, input int p1, input int p2, input int p3,
                         input int nfr, input int pct, output int nbeats);
        int pats[4];
        int fr, bif, budget;
        bit prev_stall, prev_lasths;
        int sd;
        bit su, sl;
        beat_t e;
        pats = '{p0, p1, p2, p3};
        expq.delete();
        for (int f = 0; f < nfr; f++)
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) begin
                    e.data = pix_model(x, y, pats[f]);
                    e.user = (x == 0 && y == 0);
                    e.last = (x == 3 && y == 2);
                    expq.push_back(e);
                end
        fr = 0; bif = 0; nbeats = 0; budget = 0;
        prev_stall = 0; prev_lasths = 0;
        sd = 0; su = 0; sl = 0;
        pattern_a = 2'(pats[0]);
        cont_a    = (nfr > 1);
        tready_a  = 1'b0;
        chk("idle_tvalid", int'(tvalid_a), 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_latency_tvalid", int'(tvalid_a), 1);
        while (expq.size() > 0 && budget < 2000) begin
            budget++;
            chk("frame_done", int'(done_a), int'(prev_lasths));
            chk("tvalid_held", int'(tvalid_a), 1);
            chk("busy", int'(busy_a), 1);
            tready_a  = ($urandom_range(99) < pct);
            pattern_a = (bif >= 5) ? 2'(pats[fr + 1]) : 2'(pats[fr]);
            cont_a    = (fr < nfr - 1);
            if (prev_stall) begin
                chk("stall_tdata", int'(tdata_a), sd);
                chk("stall_tuser", int'(tuser_a), int'(su));
                chk("stall_tlast", int'(tlast_a), int'(sl));
            end
            prev_lasths = 0;
            if (tvalid_a && tready_a) begin
                e = expq.pop_front();
                chk("beat_tdata", int'(tdata_a), e.data);
                chk("beat_tuser", int'(tuser_a), int'(e.user));
                chk("beat_tlast", int'(tlast_a), int'(e.last));
                nbeats++;
                bif++;
                if (e.last) begin
                    fr++;
                    bif = 0;
                    prev_lasths = 1;
                    cnt_model_a++;
                end
                prev_stall = 0;
            end else begin
                prev_stall = tvalid_a;
                sd = int'(tdata_a);
                su = tuser_a;
                sl = tlast_a;
            end
            tick();
        end
        if (budget >= 2000) chk("run_a_timeout", budget, 0);
        tready_a = 1'b0;
        chk("end_frame_done", int'(done_a), 1);
        chk("end_frame_cnt", int'(cnt_a), cnt_model_a % 65536);
        chk("end_tvalid", int'(tvalid_a), 0);
        chk("end_busy", int'(busy_a), 0);
        tick();
        chk("done_one_cycle", int'(done_a), 0);
    endtask

    initial begin
        int nb, k, budget, ndone;

        sc[0] = '{1, 1, 1, 1, 1, 100, 12};
        sc[1] = '{1, 1, 1, 1, 1, 50, 12};
        sc[2] = '{0, 0, 0, 0, 3, 100, 36};
        sc[3] = '{2, 3, 3, 3, 2, 100, 24};
        sc[4] = '{3, 0, 1, 2, 3, 60, 36};

        pv[0] = '{8, 0, 255};
        pv[1] = '{0, 8, 255};
        pv[2] = '{8, 8, 0};
        pv[3] = '{0, 0, 0};
        pv[4] = '{15, 7, 255};
        pv[5] = '{7, 15, 255};

        arst_n = 1'b0;
        start_a = 0; cont_a = 0; tready_a = 0; pattern_a = 0;
        start_b = 0; cont_b = 0; tready_b = 0; pattern_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tdata", int'(tdata_a), 0);
        chk("rst_tvalid", int'(tvalid_a), 0);
        chk("rst_tlast", int'(tlast_a), 0);
        chk("rst_tuser", int'(tuser_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        arst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_a(sc[i].p0, sc[i].p1, sc[i].p2, sc[i].p3, sc[i].nfr, sc[i].pct, nb);
            chk("scenario_beats", nb, sc[i].exp_beats);
            repeat (2) tick();
        end

        // Reset in the middle of a frame, on beat 7
        pattern_a = 2'd1; tready_a = 1'b1; cont_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (6) tick();
        chk("beat7_tdata", int'(tdata_a), 2);
        arst_n = 1'b0;
        #1;
        chk("arst_tvalid", int'(tvalid_a), 0);
        chk("arst_tlast", int'(tlast_a), 0);
        chk("arst_tuser", int'(tuser_a), 0);
        chk("arst_tdata", int'(tdata_a), 0);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_cnt", int'(cnt_a), 0);
        tick();
        arst_n = 1'b1;
        tready_a = 1'b0;
        tick();
        chk("post_rst_idle", int'(tvalid_a), 0);
        cnt_model_a = 0;
        run_a(1, 1, 1, 1, 1, 100, nb);
        chk("post_rst_beats", nb, 12);

        // Instance B: 16x16 checkerboard frame
        tready_b = 1'b1; cont_b = 1'b0; pattern_b = 2'd3;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_first_tuser", int'(tuser_b), 1);
        k = 0; budget = 0;
        while (k < 256 && budget < 400) begin
            budget++;
            if (tvalid_b) begin
                capt[k] = int'(tdata_b);
                k++;
            end
            tick();
        end
        chk("b_beats", k, 256);
        chk("b_done", int'(done_b), 1);
        chk("b_cnt1", int'(cnt_b), 1);
        for (int i = 0; i < 6; i++)
            chk("b_checker_pixel", capt[pv[i].y * 16 + pv[i].x], pv[i].exp);

        // Four more continuous frames: five total wraps a 2-bit counter to 1
        cont_b = 1'b1; pattern_b = 2'd0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ndone = 0; budget = 0;
        while (ndone < 4 && budget < 1200) begin
            budget++;
            if (done_b) ndone++;
            cont_b = (ndone < 3);
            tick();
        end
        chk("b_wrap_frames", ndone, 4);
        chk("b_wrap_cnt", int'(cnt_b), 1);
        chk("b_idle_after", int'(tvalid_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
